// File: rtl/led_display_pkg.sv
// Shared types and constants for the LED matrix serial link receive path.
package led_display_pkg;

  typedef enum logic {
    SS_IDLE  = 1'b0,
    SS_SHIFT = 1'b1
  } state_t;

  localparam int unsigned R_LSB            = 0;
  localparam int unsigned G_LSB            = 8;
  localparam int unsigned B_LSB            = 16;
  localparam int unsigned PIXEL_W          = 24;
  localparam int unsigned BITS_PER_CHANNEL = 8;

  function automatic int unsigned bit_period_cycles(input int unsigned sys_clk_freq,
                                                    input int unsigned write_freq);
    return sys_clk_freq / write_freq;
  endfunction

endpackage

// File: rtl/led_display_sync_edge.sv
// Two-flop synchroniser for a bundle of lines; bit 0 is the clock line and gets a rising-edge detect.
module led_display_sync_edge #(
  parameter int unsigned WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rise
);

  logic [WIDTH-1:0] meta;
  logic             prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
      prev <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
      prev <= q[0];
    end
  end

  assign rise = q[0] & ~prev;

endmodule

// File: rtl/led_display_rx_phy.sv
// Deserialiser for the LED matrix serial link: rebuilds top/bottom 24-bit pixels from six serial lines.
module led_display_rx_phy
  import led_display_pkg::*;
#(
  parameter int unsigned WRITE_FREQ      = 1_000_000,
  parameter int unsigned SYS_CLK_FREQ    = 100_000_000,
  parameter int unsigned TIMEOUT_PERIODS = 4
) (
  input  logic                 clk_in,
  input  logic                 n_reset_in,
  input  logic                 enable_in,
  input  logic                 bit_clk_in,
  input  logic [2:0]           rgb_top_in,
  input  logic [2:0]           rgb_bot_in,
  output logic [PIXEL_W-1:0]   pixel_top_out,
  output logic [PIXEL_W-1:0]   pixel_bot_out,
  output logic                 pixel_valid_out,
  input  logic                 pixel_ready_in,
  output logic                 overrun_out,
  output logic                 timeout_out
);

  localparam int unsigned TIMEOUT_CYCLES = TIMEOUT_PERIODS * bit_period_cycles(SYS_CLK_FREQ, WRITE_FREQ);
  localparam int unsigned TW             = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CW             = $clog2(BITS_PER_CHANNEL + 1);

  logic [6:0]                        sync_q;
  logic                              rise;
  logic [5:0]                        data_s;
  logic [5:0][BITS_PER_CHANNEL-1:0]  shreg;
  state_t                            state;
  logic [CW-1:0]                     bit_cnt;
  logic [TW-1:0]                     tmo_cnt;
  logic                              complete;
  logic [PIXEL_W-1:0]                pix_top;
  logic [PIXEL_W-1:0]                pix_bot;

  // Clock and data share one synchroniser so sampled bits stay aligned with the detected edge.
  led_display_sync_edge #(.WIDTH(7)) u_sync (
    .clk   (clk_in),
    .rst_n (n_reset_in),
    .d     ({rgb_bot_in, rgb_top_in, bit_clk_in}),
    .q     (sync_q),
    .rise  (rise)
  );

  assign data_s = sync_q[6:1];

  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      state       <= SS_IDLE;
      bit_cnt     <= '0;
      tmo_cnt     <= '0;
      shreg       <= '0;
      complete    <= 1'b0;
      timeout_out <= 1'b0;
    end else begin
      complete    <= 1'b0;
      timeout_out <= 1'b0;
      if (!enable_in) begin
        state   <= SS_IDLE;
        bit_cnt <= '0;
        tmo_cnt <= '0;
        shreg   <= '0;
      end else begin
        case (state)
          SS_IDLE: begin
            if (rise) begin
              for (int unsigned c = 0; c < 6; c++) shreg[c] <= {shreg[c][6:0], data_s[c]};
              bit_cnt <= CW'(1);
              tmo_cnt <= '0;
              state   <= SS_SHIFT;
            end
          end
          SS_SHIFT: begin
            if (rise) begin
              for (int unsigned c = 0; c < 6; c++) shreg[c] <= {shreg[c][6:0], data_s[c]};
              tmo_cnt <= '0;
              if (bit_cnt == CW'(BITS_PER_CHANNEL - 1)) begin
                bit_cnt  <= '0;
                complete <= 1'b1;
                state    <= SS_IDLE;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end else if (tmo_cnt == TW'(TIMEOUT_CYCLES)) begin
              shreg       <= '0;
              bit_cnt     <= '0;
              tmo_cnt     <= '0;
              timeout_out <= 1'b1;
              state       <= SS_IDLE;
            end else begin
              tmo_cnt <= tmo_cnt + 1'b1;
            end
          end
          default: state <= SS_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    pix_top = '0;
    pix_bot = '0;
    pix_top[R_LSB +: BITS_PER_CHANNEL] = shreg[0];
    pix_top[G_LSB +: BITS_PER_CHANNEL] = shreg[1];
    pix_top[B_LSB +: BITS_PER_CHANNEL] = shreg[2];
    pix_bot[R_LSB +: BITS_PER_CHANNEL] = shreg[3];
    pix_bot[G_LSB +: BITS_PER_CHANNEL] = shreg[4];
    pix_bot[B_LSB +: BITS_PER_CHANNEL] = shreg[5];
  end

  // Shift registers are untouched in the cycle after completion, so the output stage loads from them directly.
  always_ff @(posedge clk_in or negedge n_reset_in) begin
    if (!n_reset_in) begin
      pixel_top_out   <= '0;
      pixel_bot_out   <= '0;
      pixel_valid_out <= 1'b0;
      overrun_out     <= 1'b0;
    end else begin
      if (complete) begin
        if (!pixel_valid_out || pixel_ready_in) begin
          pixel_top_out   <= pix_top;
          pixel_bot_out   <= pix_bot;
          pixel_valid_out <= 1'b1;
        end else begin
          overrun_out <= 1'b1;
        end
      end else if (pixel_ready_in) begin
        pixel_valid_out <= 1'b0;
      end
      if (!enable_in) overrun_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_led_display_rx_phy.sv
// Scoreboard bench for led_display_rx_phy: a serial transmitter model feeds pixels, a monitor checks handshakes.
module tb_led_display_rx_phy;

  localparam int HALF = 10;

  logic        clk = 1'b0;
  logic        n_reset;
  logic        enable;
  logic        bit_clk;
  logic        ready;
  logic [2:0]  top_d;
  logic [2:0]  bot_d;
  logic [23:0] pixel_top;
  logic [23:0] pixel_bot;
  logic        valid;
  logic        overrun;
  logic        timeout;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last8 = 0;
  int tmo_seen = 0;
  bit lat_arm = 1'b0;
  bit prev_valid = 1'b0;
  event ev8;

  logic [23:0] exp_top_q[$];
  logic [23:0] exp_bot_q[$];

  led_display_rx_phy #(
    .WRITE_FREQ      (1_000_000),
    .SYS_CLK_FREQ    (100_000_000),
    .TIMEOUT_PERIODS (4)
  ) dut (
    .clk_in          (clk),
    .n_reset_in      (n_reset),
    .enable_in       (enable),
    .bit_clk_in      (bit_clk),
    .rgb_top_in      (top_d),
    .rgb_bot_in      (bot_d),
    .pixel_top_out   (pixel_top),
    .pixel_bot_out   (pixel_bot),
    .pixel_valid_out (valid),
    .pixel_ready_in  (ready),
    .overrun_out     (overrun),
    .timeout_out     (timeout)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Transmitter model: data changes with the falling bit clock, MSB of each channel first.
  task automatic drive_bits(input logic [23:0] t, input logic [23:0] b, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      @(posedge clk); #2;
      bit_clk = 1'b0;
      for (int c = 0; c < 3; c++) begin
        top_d[c] = t[c*8 + 7 - i];
        bot_d[c] = b[c*8 + 7 - i];
      end
      repeat (HALF) @(posedge clk);
      #2;
      bit_clk = 1'b1;
      if (i == 7) begin
        last8 = cyc;
        -> ev8;
      end
      repeat (HALF - 1) @(posedge clk);
    end
    @(posedge clk); #2;
    bit_clk = 1'b0;
  endtask

  task automatic send_exp(input logic [23:0] t, input logic [23:0] b);
    exp_top_q.push_back(t);
    exp_bot_q.push_back(b);
    drive_bits(t, b, 8);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_top_q.size() != 0 && n < 3000) begin
      @(posedge clk);
      n++;
    end
    chk(name, exp_top_q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    logic [23:0] et;
    logic [23:0] eb;
    int lat;
    if (valid && ready) begin
      if (exp_top_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pixel actual top=%h bot=%h required none", pixel_top, pixel_bot);
      end else begin
        et = exp_top_q.pop_front();
        eb = exp_bot_q.pop_front();
        chk("pixel_top", pixel_top, et);
        chk("pixel_bot", pixel_bot, eb);
      end
    end
    if (timeout) tmo_seen++;
    if (lat_arm && valid && !prev_valid) begin
      lat = cyc - (last8 + 1);
      checks++;
      if (lat < 2 || lat > 4) begin
        errors++;
        $display("FAIL latency actual=%0d required=3+-1", lat);
      end
    end
    prev_valid = valid;
  end

  initial begin
    #500_000;
    errors++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    logic [23:0] ra, rb;
    int base;
    n_reset = 1'b0; enable = 1'b1; bit_clk = 1'b0; ready = 1'b1;
    top_d = '0; bot_d = '0;
    repeat (3) @(posedge clk);
    #2;
    chk("reset_valid", valid, 0);
    chk("reset_top", pixel_top, 0);
    chk("reset_bot", pixel_bot, 0);
    chk("reset_overrun", overrun, 0);
    chk("reset_timeout", timeout, 0);
    n_reset = 1'b1;
    repeat (5) @(posedge clk);

    send_exp(24'h00FF00, 24'h0000FF);
    wait_drain("single_drain");
    chk("single_overrun", overrun, 0);

    lat_arm = 1'b1;
    for (int k = 0; k < 16; k++) begin
      ra = 24'($urandom);
      rb = 24'($urandom);
      send_exp(ra, rb);
    end
    wait_drain("random_drain");
    repeat (4) @(posedge clk);
    lat_arm = 1'b0;

    // Backpressure: A held, B dropped
    ready = 1'b0;
    exp_top_q.push_back(24'h123456);
    exp_bot_q.push_back(24'h123456);
    drive_bits(24'h123456, 24'h123456, 8);
    drive_bits(24'hABCDEF, 24'hABCDEF, 8);
    repeat (10) @(posedge clk);
    #2;
    chk("bp_valid", valid, 1);
    chk("bp_hold_top", pixel_top, 24'h123456);
    chk("bp_hold_bot", pixel_bot, 24'h123456);
    chk("bp_overrun", overrun, 1);
    ready = 1'b1;
    wait_drain("bp_drain");
    repeat (2) @(posedge clk);
    #2;
    chk("bp_valid_after", valid, 0);
    chk("bp_overrun_sticky", overrun, 1);
    enable = 1'b0;
    @(posedge clk); #2;
    enable = 1'b1;
    @(posedge clk); #2;
    chk("bp_overrun_cleared", overrun, 0);

    // Timeout after 5 bits
    base = tmo_seen;
    drive_bits(24'h5A5A5A, 24'hC3C3C3, 5);
    repeat (500) @(posedge clk);
    chk("timeout_pulses", tmo_seen - base, 1);
    send_exp(24'hFFFFFF, 24'hFFFFFF);
    wait_drain("after_timeout_drain");

    // Reset mid-pixel with a pending output pixel
    ready = 1'b0;
    drive_bits(24'h5A5A5A, 24'hA5A5A5, 8);
    repeat (6) @(posedge clk);
    #2;
    chk("pending_before_reset", valid, 1);
    drive_bits(24'h0F0F0F, 24'hF0F0F0, 3);
    @(posedge clk); #2;
    n_reset = 1'b0;
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_top", pixel_top, 0);
    chk("rst_bot", pixel_bot, 0);
    chk("rst_overrun", overrun, 0);
    repeat (3) @(posedge clk);
    #2;
    n_reset = 1'b1;
    ready = 1'b1;
    repeat (3) @(posedge clk);
    send_exp(24'h800001, 24'h800001);
    wait_drain("after_reset_drain");

    // Enable dropped mid-pixel
    drive_bits(24'hFFFFFF, 24'hFFFFFF, 4);
    @(posedge clk); #2;
    enable = 1'b0;
    @(posedge clk); #2;
    enable = 1'b1;
    send_exp(24'h3C5A96, 24'hC3A569);
    wait_drain("after_enable_drain");

    // Ready rises in the cycle the next pixel completes
    ready = 1'b0;
    send_exp(24'h111111, 24'h222222);
    repeat (10) @(posedge clk);
    exp_top_q.push_back(24'h333333);
    exp_bot_q.push_back(24'h444444);
    fork
      drive_bits(24'h333333, 24'h444444, 8);
      begin
        @(ev8);
        repeat (3) @(posedge clk);
        #2;
        ready = 1'b1;
        @(posedge clk); #2;
        ready = 1'b0;
      end
    join
    repeat (4) @(posedge clk);
    #2;
    chk("simul_overrun", overrun, 0);
    chk("simul_valid", valid, 1);
    chk("simul_top", pixel_top, 24'h333333);
    chk("simul_queue", exp_top_q.size(), 1);
    ready = 1'b1;
    wait_drain("simul_drain");
    repeat (4) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
